uio_spi_master: RTL and testbench



---
 rtl/uio_spi_master.sv | 151 +++++++++++++++
 tb/tb_uio_spi_master.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uio_spi_master.sv
// UIO bus-mapped SPI master (mode 0): DATA/CTRL/DIV/STATUS registers, one chip select,
// MSB-first shifting with a programmable SCLK half-period and a level interrupt.
module uio_spi_master #(
    parameter int unsigned AddrWidth = 15,
    parameter int unsigned BusWidth  = 32,
    parameter int unsigned CsIndex   = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [AddrWidth-1:0] address,
    input  logic [BusWidth-1:0]  busdatain,
    output logic [BusWidth-1:0]  busdataout,
    input  logic                 write,
    input  logic                 read,
    input  logic [3:0]           cs,
    output logic                 spi_cs_n,
    output logic                 spi_sclk,
    output logic                 spi_mosi,
    input  logic                 spi_miso,
    output logic                 irq
);

    localparam logic [2:0] StIdle  = 3'd0;
    localparam logic [2:0] StSetup = 3'd1;
    localparam logic [2:0] StHigh  = 3'd2;
    localparam logic [2:0] StLow   = 3'd3;
    localparam logic [2:0] StHold  = 3'd4;

    logic [2:0]  state;
    logic [4:0]  len;
    logic        ien;
    logic [15:0] div;
    logic [4:0]  cur_len;
    logic [15:0] cur_div;
    logic [15:0] timer;
    logic [4:0]  bit_cnt;
    logic [31:0] tx_shift;
    logic [31:0] rx_shift;
    logic        done;
    logic        overrun;
    logic        busy;
    logic [31:0] rd_word;

    logic sel, wr_data, wr_ctrl, wr_div, wr_stat, rd_en;
    logic unused_bits;

    assign sel     = cs[CsIndex];
    assign wr_data = write & sel & (address[1:0] == 2'd0);
    assign wr_ctrl = write & sel & (address[1:0] == 2'd1);
    assign wr_div  = write & sel & (address[1:0] == 2'd2);
    assign wr_stat = write & sel & (address[1:0] == 2'd3);
    assign rd_en   = read & sel;
    assign busy    = (state != StIdle);
    assign irq     = done & ien;

    assign unused_bits = ^{address, busdatain, cs};

    always_comb begin
        rd_word = 32'd0;
        case (address[1:0])
            2'd0:    rd_word = rx_shift;
            2'd1:    rd_word = {23'd0, ien, 3'd0, len};
            2'd2:    rd_word = {16'd0, div};
            default: rd_word = {29'd0, overrun, done, busy};
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= StIdle;
            len        <= 5'd0;
            ien        <= 1'b0;
            div        <= 16'd0;
            cur_len    <= 5'd0;
            cur_div    <= 16'd0;
            timer      <= 16'd0;
            bit_cnt    <= 5'd0;
            tx_shift   <= 32'd0;
            rx_shift   <= 32'd0;
            done       <= 1'b0;
            overrun    <= 1'b0;
            spi_cs_n   <= 1'b1;
            spi_sclk   <= 1'b0;
            spi_mosi   <= 1'b0;
            busdataout <= '0;
        end else begin
            if (wr_ctrl) begin
                len <= busdatain[4:0];
                ien <= busdatain[8];
            end
            if (wr_div) div <= busdatain[15:0];
            if (wr_stat && busdatain[1]) done <= 1'b0;
            if (wr_stat && busdatain[2]) overrun <= 1'b0;
            if (wr_data && busy) overrun <= 1'b1;
            if (rd_en) busdataout <= BusWidth'(rd_word);

            if (state == StIdle) begin
                if (wr_data) begin
                    state    <= StSetup;
                    cur_len  <= len;
                    cur_div  <= div;
                    timer    <= 16'd0;
                    bit_cnt  <= 5'd0;
                    // Left-align the frame so the next bit is always tx_shift[30]
                    tx_shift <= busdatain[31:0] << (5'd31 - len);
                    spi_mosi <= busdatain[len];
                    spi_cs_n <= 1'b0;
                    rx_shift <= 32'd0;
                    done     <= 1'b0;
                end
            end else if (timer != cur_div) begin
                timer <= timer + 16'd1;
            end else begin
                timer <= 16'd0;
                case (state)
                    StSetup: begin
                        state    <= StHigh;
                        spi_sclk <= 1'b1;
                        rx_shift <= {rx_shift[30:0], spi_miso};
                    end
                    StHigh: begin
                        state    <= StLow;
                        spi_sclk <= 1'b0;
                        if (bit_cnt != cur_len) begin
                            spi_mosi <= tx_shift[30];
                            tx_shift <= tx_shift << 1;
                        end
                    end
                    StLow: begin
                        if (bit_cnt == cur_len) begin
                            state <= StHold;
                        end else begin
                            bit_cnt  <= bit_cnt + 5'd1;
                            state    <= StHigh;
                            spi_sclk <= 1'b1;
                            rx_shift <= {rx_shift[30:0], spi_miso};
                        end
                    end
                    default: begin
                        // Placed after the STATUS clear so completion wins a same-cycle clear
                        state    <= StIdle;
                        spi_cs_n <= 1'b1;
                        spi_mosi <= 1'b0;
                        done     <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uio_spi_master.sv
// Directed self-checking bench for uio_spi_master: register access, frame timing,
// loopback data, interrupt, overrun and asynchronous reset mid-transfer.
module tb_uio_spi_master;

    logic        clk;
    logic        reset;
    logic [14:0] address;
    logic [31:0] busdatain;
    logic [31:0] busdataout;
    logic        write;
    logic        read;
    logic [3:0]  cs;
    logic        spi_cs_n;
    logic        spi_sclk;
    logic        spi_mosi;
    logic        spi_miso;
    logic        irq;
    logic        loop_en;
    logic        miso_val;

    int n_checks = 0;
    int n_errors = 0;

    uio_spi_master #(
        .AddrWidth(15),
        .BusWidth (32),
        .CsIndex  (0)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .address   (address),
        .busdatain (busdatain),
        .busdataout(busdataout),
        .write     (write),
        .read      (read),
        .cs        (cs),
        .spi_cs_n  (spi_cs_n),
        .spi_sclk  (spi_sclk),
        .spi_mosi  (spi_mosi),
        .spi_miso  (spi_miso),
        .irq       (irq)
    );

    assign spi_miso = loop_en ? spi_mosi : miso_val;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic bus_write(input logic [1:0] addr, input logic [31:0] data,
                             input logic [3:0] cs_val);
        @(negedge clk);
        address   = {13'd0, addr};
        busdatain = data;
        cs        = cs_val;
        write     = 1'b1;
        @(negedge clk);
        write = 1'b0;
        cs    = 4'd0;
    endtask

    task automatic bus_read(input logic [1:0] addr, output logic [31:0] data);
        @(negedge clk);
        address = {13'd0, addr};
        cs      = 4'd1;
        read    = 1'b1;
        @(negedge clk);
        read = 1'b0;
        cs   = 4'd0;
        data = busdataout;
    endtask

    // Called on the first negedge after the DATA write; watches until spi_cs_n rises.
    task automatic run_xfer(output int cycles, output int pulses, output logic [31:0] bits,
                            output int min_hi, output int max_hi);
        logic prev;
        int   hi;
        cycles = 0;
        pulses = 0;
        bits   = 32'd0;
        min_hi = 1000;
        max_hi = 0;
        prev   = 1'b0;
        hi     = 0;
        while (spi_cs_n == 1'b0 && cycles < 5000) begin
            cycles++;
            if (spi_sclk) begin
                hi++;
                if (!prev) begin
                    pulses++;
                    bits = {bits[30:0], spi_mosi};
                end
            end else if (prev) begin
                if (hi < min_hi) min_hi = hi;
                if (hi > max_hi) max_hi = hi;
                hi = 0;
            end
            prev = spi_sclk;
            @(negedge clk);
        end
        if (cycles >= 5000) check("xfer_timeout", 32'(cycles), 32'd0);
    endtask

    logic [31:0] rd;
    int          cyc, pul, mn, mx;
    logic [31:0] bits;

    initial begin
        reset     = 1'b1;
        address   = '0;
        busdatain = '0;
        write     = 1'b0;
        read      = 1'b0;
        cs        = 4'd0;
        loop_en   = 1'b0;
        miso_val  = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // Reset state
        for (int a = 0; a < 4; a++) begin
            bus_read(2'(a), rd);
            check($sformatf("reset_reg%0d", a), rd, 32'd0);
        end
        check("reset_cs_n", 32'(spi_cs_n), 32'd1);
        check("reset_sclk", 32'(spi_sclk), 32'd0);
        check("reset_irq", 32'(irq), 32'd0);

        // Deselected write has no effect
        bus_write(2'd2, 32'h1234, 4'b0010);
        bus_read(2'd2, rd);
        check("cs_off_div", rd, 32'd0);

        // DIV=0, 8 bits, loopback
        loop_en = 1'b1;
        bus_write(2'd2, 32'd0, 4'd1);
        bus_write(2'd1, 32'd7, 4'd1);
        bus_write(2'd0, 32'hA5, 4'd1);
        run_xfer(cyc, pul, bits, mn, mx);
        check("t2_busy_cycles", 32'(cyc), 32'd18);
        check("t2_pulses", 32'(pul), 32'd8);
        check("t2_high_min", 32'(mn), 32'd1);
        check("t2_high_max", 32'(mx), 32'd1);
        check("t2_mosi_bits", bits, 32'hA5);
        check("t2_mosi_idle", 32'(spi_mosi), 32'd0);
        bus_read(2'd0, rd);
        check("t2_rx", rd, 32'hA5);
        bus_read(2'd3, rd);
        check("t2_status", rd, 32'h2);
        bus_read(2'd1, rd);
        check("t2_ctrl", rd, 32'h7);

        // DIV=3, 32 bits, miso tied high
        loop_en  = 1'b0;
        miso_val = 1'b1;
        bus_write(2'd2, 32'd3, 4'd1);
        bus_write(2'd1, 32'd31, 4'd1);
        bus_write(2'd0, 32'h8000_0001, 4'd1);
        run_xfer(cyc, pul, bits, mn, mx);
        check("t3_busy_cycles", 32'(cyc), 32'd264);
        check("t3_pulses", 32'(pul), 32'd32);
        check("t3_high_min", 32'(mn), 32'd4);
        check("t3_high_max", 32'(mx), 32'd4);
        check("t3_mosi_bits", bits, 32'h8000_0001);
        bus_read(2'd0, rd);
        check("t3_rx", rd, 32'hFFFF_FFFF);
        bus_read(2'd2, rd);
        check("t3_div", rd, 32'd3);

        // Interrupt with a 1-bit frame
        loop_en = 1'b1;
        bus_write(2'd2, 32'd0, 4'd1);
        bus_write(2'd1, 32'h100, 4'd1);
        bus_write(2'd0, 32'h1, 4'd1);
        check("t4_irq_busy", 32'(irq), 32'd0);
        run_xfer(cyc, pul, bits, mn, mx);
        check("t4_busy_cycles", 32'(cyc), 32'd4);
        check("t4_irq_done", 32'(irq), 32'd1);
        bus_read(2'd0, rd);
        check("t4_rx", rd, 32'h1);
        bus_write(2'd3, 32'h2, 4'd1);
        check("t4_irq_cleared", 32'(irq), 32'd0);

        // Overrun: second DATA write mid-frame is ignored
        bus_write(2'd2, 32'd1, 4'd1);
        bus_write(2'd1, 32'd7, 4'd1);
        bus_write(2'd0, 32'h3C, 4'd1);
        fork
            run_xfer(cyc, pul, bits, mn, mx);
            begin
                repeat (5) @(negedge clk);
                bus_write(2'd0, 32'hFF, 4'd1);
            end
        join
        check("t5_busy_cycles", 32'(cyc), 32'd36);
        check("t5_mosi_bits", bits, 32'h3C);
        bus_read(2'd0, rd);
        check("t5_rx", rd, 32'h3C);
        bus_read(2'd3, rd);
        check("t5_status", rd, 32'h6);
        bus_write(2'd3, 32'h4, 4'd1);
        bus_read(2'd3, rd);
        check("t5_status_clr", rd, 32'h2);

        // Asynchronous reset while SCLK is high
        bus_write(2'd2, 32'd0, 4'd1);
        bus_write(2'd1, 32'd7, 4'd1);
        bus_write(2'd0, 32'hA5, 4'd1);
        @(negedge clk);
        check("t6_sclk_pre", 32'(spi_sclk), 32'd1);
        #1 reset = 1'b1;
        #1;
        check("t6_cs_n", 32'(spi_cs_n), 32'd1);
        check("t6_sclk", 32'(spi_sclk), 32'd0);
        check("t6_mosi", 32'(spi_mosi), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        bus_read(2'd3, rd);
        check("t6_status", rd, 32'd0);
        bus_read(2'd0, rd);
        check("t6_rx", rd, 32'd0);
        bus_write(2'd1, 32'd7, 4'd1);
        bus_write(2'd0, 32'h5A, 4'd1);
        run_xfer(cyc, pul, bits, mn, mx);
        check("t6_busy_cycles", 32'(cyc), 32'd18);
        check("t6_mosi_bits", bits, 32'h5A);
        bus_read(2'd0, rd);
        check("t6_rx_after", rd, 32'h5A);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
